// File: rtl/ball_engine.sv
// Pong ball: serve hold, per-frame motion with edge bounces, and one-cycle raster of the ball square.
// Optional BALL_HIT_FLASH_EN: ball flashes white for 7 frames after each bounce.
module ball_engine #(
   parameter int         HDISP        = 640,
   parameter int         VDISP        = 480,
   parameter int         BALL_SIZE    = 8,
   parameter int         SPEED        = 2,
   parameter int         SERVE_FRAMES = 60,
   parameter logic [7:0] BALL_COLOR   = 8'h3F
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [11:0] hcount,
   input  logic [10:0] vcount,
   input  logic        pause,
   input  logic        serve,
   output logic        drawBall,
   output logic [2:0]  red,
   output logic [2:0]  green,
   output logic [1:0]  blue,
   output logic [11:0] ball_x,
   output logic [10:0] ball_y,
   output logic [7:0]  bounce_count
);

   localparam int          CW         = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES);
   localparam logic [CW-1:0] SERVE_LAST = CW'(SERVE_FRAMES - 1);
   localparam logic [12:0] X_LIM      = 13'(HDISP);
   localparam logic [11:0] Y_LIM      = 12'(VDISP);
   localparam logic [12:0] X_REACH    = 13'(BALL_SIZE + SPEED);
   localparam logic [11:0] Y_REACH    = 12'(BALL_SIZE + SPEED);
   localparam logic [12:0] X_SIZE     = 13'(BALL_SIZE);
   localparam logic [11:0] Y_SIZE     = 12'(BALL_SIZE);
   localparam logic [11:0] X_SPD      = 12'(SPEED);
   localparam logic [10:0] Y_SPD      = 11'(SPEED);
   localparam logic [11:0] X_MAX      = 12'(HDISP - BALL_SIZE);
   localparam logic [10:0] Y_MAX      = 11'(VDISP - BALL_SIZE);
   localparam logic [11:0] X_CTR      = 12'((HDISP - BALL_SIZE) / 2);
   localparam logic [10:0] Y_CTR      = 11'((VDISP - BALL_SIZE) / 2);

   typedef enum logic [0:0] {S_SERVE = 1'b0, S_PLAY = 1'b1} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] serve_cnt_q, serve_cnt_d;
   logic [11:0]   ball_x_q, ball_x_d;
   logic [10:0]   ball_y_q, ball_y_d;
   logic          dx_q, dx_d, dy_q, dy_d;
   logic [7:0]    bounce_q, bounce_d;
   logic          draw_q, draw_d;
   logic [7:0]    color_q, color_d;
   logic          frame_tick_s, move_s, x_bounce_s, y_bounce_s, hit_s;
   logic [12:0]   x_far_s, x_end_s;
   logic [11:0]   y_far_s, y_end_s;
   logic [7:0]    ball_color_s;
`ifdef BALL_HIT_FLASH_EN
   logic [2:0]    flash_q, flash_d;
`endif

   assign frame_tick_s = (hcount == 12'd0) && (vcount == 11'(VDISP));
   assign move_s       = frame_tick_s && (state_q == S_PLAY) && !pause;
   assign x_far_s      = {1'b0, ball_x_q} + X_REACH;
   assign y_far_s      = {1'b0, ball_y_q} + Y_REACH;
   assign x_end_s      = {1'b0, ball_x_q} + X_SIZE;
   assign y_end_s      = {1'b0, ball_y_q} + Y_SIZE;

   // State register and all datapath flops
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_SERVE;
         serve_cnt_q <= '0;
         ball_x_q    <= X_CTR;
         ball_y_q    <= Y_CTR;
         dx_q        <= 1'b1;
         dy_q        <= 1'b1;
         bounce_q    <= 8'd0;
         draw_q      <= 1'b0;
         color_q     <= 8'h00;
`ifdef BALL_HIT_FLASH_EN
         flash_q     <= 3'd0;
`endif
      end else begin
         state_q     <= state_d;
         serve_cnt_q <= serve_cnt_d;
         ball_x_q    <= ball_x_d;
         ball_y_q    <= ball_y_d;
         dx_q        <= dx_d;
         dy_q        <= dy_d;
         bounce_q    <= bounce_d;
         draw_q      <= draw_d;
         color_q     <= color_d;
`ifdef BALL_HIT_FLASH_EN
         flash_q     <= flash_d;
`endif
      end
   end

   // Next-state: serve pulse always wins; the last serve tick hands over to play without moving
   always_comb begin
      state_d = state_q;
      if (serve) begin
         state_d = S_SERVE;
      end else if (frame_tick_s && (state_q == S_SERVE) && (serve_cnt_q == SERVE_LAST)) begin
         state_d = S_PLAY;
      end else begin
         state_d = state_q;
      end
   end

   // Motion, bounce detection and serve counting
   always_comb begin
      serve_cnt_d = serve_cnt_q;
      ball_x_d    = ball_x_q;
      ball_y_d    = ball_y_q;
      dx_d        = dx_q;
      dy_d        = dy_q;
      x_bounce_s  = 1'b0;
      y_bounce_s  = 1'b0;
      case (state_q)
         S_SERVE: begin
            if (frame_tick_s) begin
               serve_cnt_d = (serve_cnt_q == SERVE_LAST) ? '0 : serve_cnt_q + CW'(1);
            end else begin
               serve_cnt_d = serve_cnt_q;
            end
         end
         S_PLAY: begin
            if (move_s) begin
               if (dx_q) begin
                  if (x_far_s >= X_LIM) begin
                     ball_x_d = X_MAX; dx_d = 1'b0; x_bounce_s = 1'b1;
                  end else begin
                     ball_x_d = ball_x_q + X_SPD;
                  end
               end else if (ball_x_q <= X_SPD) begin
                  ball_x_d = 12'd0; dx_d = 1'b1; x_bounce_s = 1'b1;
               end else begin
                  ball_x_d = ball_x_q - X_SPD;
               end
               if (dy_q) begin
                  if (y_far_s >= Y_LIM) begin
                     ball_y_d = Y_MAX; dy_d = 1'b0; y_bounce_s = 1'b1;
                  end else begin
                     ball_y_d = ball_y_q + Y_SPD;
                  end
               end else if (ball_y_q <= Y_SPD) begin
                  ball_y_d = 11'd0; dy_d = 1'b1; y_bounce_s = 1'b1;
               end else begin
                  ball_y_d = ball_y_q - Y_SPD;
               end
            end else begin
               ball_x_d = ball_x_q;
            end
         end
         default: begin
            serve_cnt_d = '0;
         end
      endcase
      if (serve) begin
         serve_cnt_d = '0;
         ball_x_d    = X_CTR;
         ball_y_d    = Y_CTR;
         dx_d        = 1'b1;
         dy_d        = 1'b1;
         x_bounce_s  = 1'b0;
         y_bounce_s  = 1'b0;
      end else begin
         serve_cnt_d = serve_cnt_d;
      end
      bounce_d = (x_bounce_s || y_bounce_s) ? bounce_q + 8'd1 : bounce_q;
   end

`ifdef BALL_HIT_FLASH_EN
   // Flash counter: reloads on a bounce tick, otherwise counts frames down to zero
   always_comb begin
      if (serve) begin
         flash_d = 3'd0;
      end else if (x_bounce_s || y_bounce_s) begin
         flash_d = 3'd7;
      end else if (frame_tick_s && (flash_q != 3'd0)) begin
         flash_d = flash_q - 3'd1;
      end else begin
         flash_d = flash_q;
      end
   end
   assign ball_color_s = (flash_q != 3'd0) ? 8'hFF : BALL_COLOR;
`else
   assign ball_color_s = BALL_COLOR;
`endif

   // Output logic: raster hit against the current position, registered next cycle
   always_comb begin
      hit_s   = (hcount >= ball_x_q) && ({1'b0, hcount} < x_end_s) &&
                (vcount >= ball_y_q) && ({1'b0, vcount} < y_end_s);
      draw_d  = hit_s;
      color_d = hit_s ? ball_color_s : 8'h00;
   end

   assign drawBall     = draw_q;
   assign red          = color_q[2:0];
   assign green        = color_q[5:3];
   assign blue         = color_q[7:6];
   assign ball_x       = ball_x_q;
   assign ball_y       = ball_y_q;
   assign bounce_count = bounce_q;

endmodule

// File: tb/tb_ball_engine.sv
// Self-checking bench for ball_engine: vector table, directed corner sequences, and randomized
// frame/serve/pause/raster traffic compared against an integer-level model of the ball's motion.
module tb_ball_engine;
   localparam int HD = 640, VD = 480, BS = 8, SP = 2, SF = 60;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, pause, serve, draw_ball;
   logic [11:0] hcount, ball_x;
   logic [10:0] vcount, ball_y;
   logic [2:0]  red, green;
   logic [1:0]  blue;
   logic [7:0]  bounce_count;

   logic        pause2, serve2, s_draw;
   logic [11:0] hc2, s_x;
   logic [10:0] vc2, s_y;
   logic [2:0]  s_red, s_green;
   logic [1:0]  s_blue;
   logic [7:0]  s_bc;

   ball_engine u_dut (
      .clk(clk), .rst(rst), .hcount(hcount), .vcount(vcount), .pause(pause), .serve(serve),
      .drawBall(draw_ball), .red(red), .green(green), .blue(blue),
      .ball_x(ball_x), .ball_y(ball_y), .bounce_count(bounce_count));

   ball_engine #(.HDISP(48), .VDISP(48), .SERVE_FRAMES(1)) u_small (
      .clk(clk), .rst(rst), .hcount(hc2), .vcount(vc2), .pause(pause2), .serve(serve2),
      .drawBall(s_draw), .red(s_red), .green(s_green), .blue(s_blue),
      .ball_x(s_x), .ball_y(s_y), .bounce_count(s_bc));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state (plain integers)
   int m_x, m_y, m_dx, m_dy, m_bc, m_play, m_cnt, m_flash;

   typedef struct { int h; int v; bit d; } rvec_t;
   rvec_t tbl[14];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int dut_col();
      return int'({blue, green, red});
   endfunction

   function automatic int exp_col();
`ifdef BALL_HIT_FLASH_EN
      return (m_flash != 0) ? 255 : 63;
`else
      return 63;
`endif
   endfunction

   task automatic m_serve();
      m_play = 0; m_cnt = 0; m_x = (HD - BS) / 2; m_y = (VD - BS) / 2;
      m_dx = 1; m_dy = 1; m_flash = 0;
   endtask

   task automatic m_axis(inout int pos, inout int dir, input int lim, output bit b);
      b = 1'b0;
      if (dir == 1) begin
         if (pos + BS + SP >= lim) begin pos = lim - BS; dir = 0; b = 1'b1; end
         else pos = pos + SP;
      end else begin
         if (pos <= SP) begin pos = 0; dir = 1; b = 1'b1; end
         else pos = pos - SP;
      end
   endtask

   task automatic m_tick(input bit p);
      bit bx, by;
      bx = 1'b0; by = 1'b0;
      if (m_play == 0) begin
         m_cnt++;
         if (m_cnt == SF) begin m_cnt = 0; m_play = 1; end
      end else if (!p) begin
         m_axis(m_x, m_dx, HD, bx);
         m_axis(m_y, m_dy, VD, by);
      end
      if (bx || by) begin
         m_bc = (m_bc + 1) % 256;
         m_flash = 7;
      end else if (m_flash > 0) begin
         m_flash--;
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic idle();
      hcount = 12'd700; vcount = 11'd500; pause = 1'b0; serve = 1'b0;
      hc2 = 12'd700; vc2 = 11'd100; pause2 = 1'b0; serve2 = 1'b0;
   endtask

   task automatic frame(input bit p, input bit s);
      hcount = 12'd0; vcount = 11'(VD); pause = p; serve = s;
      step();
      idle();
      if (s) m_serve(); else m_tick(p);
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_x"}, int'(ball_x), m_x);
      chk({tag, "_y"}, int'(ball_y), m_y);
      chk({tag, "_bounce"}, int'(bounce_count), m_bc);
   endtask

   task automatic probe(input int h, input int v, input string tag);
      bit hit;
      hit = (h >= m_x) && (h < m_x + BS) && (v >= m_y) && (v < m_y + BS);
      hcount = 12'(h); vcount = 11'(v);
      step();
      idle();
      chk({tag, "_draw"}, int'(draw_ball), int'(hit));
      chk({tag, "_colour"}, dut_col(), hit ? exp_col() : 0);
   endtask

   task automatic run_tick(input bit p, input string tag);
      frame(p, 1'b0);
      check_state(tag);
      probe(m_x + 3, m_y + 3, {tag, "_probe"});
   endtask

   task automatic small_tick();
      hc2 = 12'd0; vc2 = 11'd48;
      step();
      idle();
   endtask

   initial begin
      int sx, sy, sbc, h, v;
      idle();
      rst = 1'b1;
      m_serve(); m_bc = 0;
      repeat (3) step();
      chk("reset_x", int'(ball_x), 316);
      chk("reset_y", int'(ball_y), 236);
      chk("reset_bounce", int'(bounce_count), 0);
      chk("reset_draw", int'(draw_ball), 0);
      chk("reset_colour", dut_col(), 0);
      chk("reset_small_x", int'(s_x), 20);
      rst = 1'b0;

      // Raster table at centre position
      for (int i = 0; i < 10; i++) begin
         tbl[i].h = 315 + i; tbl[i].v = 236; tbl[i].d = (315 + i >= 316) && (315 + i <= 323);
      end
      tbl[10] = '{316, 244, 1'b0};
      tbl[11] = '{323, 244, 1'b0};
      tbl[12] = '{316, 243, 1'b1};
      tbl[13] = '{316, 235, 1'b0};
      for (int i = 0; i < 14; i++) begin
         hcount = 12'(tbl[i].h); vcount = 11'(tbl[i].v);
         step();
         chk($sformatf("raster_draw_h%0d_v%0d", tbl[i].h, tbl[i].v), int'(draw_ball), int'(tbl[i].d));
         chk($sformatf("raster_col_h%0d_v%0d", tbl[i].h, tbl[i].v), dut_col(), tbl[i].d ? 63 : 0);
      end
      idle();
      step();

      // Serve hold then first bounces
      for (int i = 1; i <= SF; i++) run_tick(1'b0, "serve");
      chk("serve_enter_play_x", int'(ball_x), 316);
      for (int k = 1; k <= 159; k++) begin
         run_tick(1'b0, "play");
         if (k == 1) begin
            chk("first_play_x", int'(ball_x), 318);
            chk("first_play_y", int'(ball_y), 238);
         end
         if (k == 118) begin
            chk("ybounce_y", int'(ball_y), 472);
            chk("ybounce_count", int'(bounce_count), 1);
         end
         if (k == 119) chk("ybounce_dir_y", int'(ball_y), 470);
         if (k >= 118 && k <= 125) begin
            probe(m_x, m_y, "flash");
`ifdef BALL_HIT_FLASH_EN
            chk($sformatf("flash_const_k%0d", k), dut_col(), (k <= 124) ? 255 : 63);
`else
            chk($sformatf("flash_const_k%0d", k), dut_col(), 63);
`endif
         end
         if (k == 158) begin
            chk("xbounce_x", int'(ball_x), 632);
            chk("xbounce_count", int'(bounce_count), 2);
         end
         if (k == 159) chk("xbounce_dir_x", int'(ball_x), 630);
      end

      // Pause holds, then serve coincident with a frame tick
      sx = m_x; sy = m_y; sbc = m_bc;
      for (int i = 0; i < 5; i++) begin
         run_tick(1'b1, "pause");
         chk("pause_hold_x", int'(ball_x), sx);
         chk("pause_hold_y", int'(ball_y), sy);
      end
      frame(1'b0, 1'b1);
      chk("serve_tick_x", int'(ball_x), 316);
      chk("serve_tick_y", int'(ball_y), 236);
      chk("serve_tick_bounce", int'(bounce_count), sbc);
      run_tick(1'b0, "after_serve");
      chk("after_serve_held_x", int'(ball_x), 316);

      // Corner hit on the small screen counts once
      small_tick();
      for (int k = 1; k <= 11; k++) begin
         small_tick();
         if (k == 9) chk("corner_pre_x", int'(s_x), 38);
         if (k == 10) begin
            chk("corner_x", int'(s_x), 40);
            chk("corner_y", int'(s_y), 40);
            chk("corner_bounce", int'(s_bc), 1);
         end
         if (k == 11) begin
            chk("corner_dir_x", int'(s_x), 38);
            chk("corner_dir_y", int'(s_y), 38);
         end
      end

      // Randomized traffic against the model
      for (int it = 0; it < 3000; it++) begin
         if ($urandom_range(0, 199) == 0) begin
            frame($urandom_range(0, 1) == 1, 1'b1);
            check_state("rand_serve");
         end else begin
            run_tick($urandom_range(0, 7) == 0, "rand");
         end
         h = m_x + int'($urandom_range(0, 11)) - 2;
         v = m_y + int'($urandom_range(0, 11)) - 2;
         if (h < 1) h = 1;
         if (v < 0) v = 0;
         probe(h, v, "rand_raster");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
